mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
module mem_port_arbiter #(
    parameter int BITSIZE      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [BITSIZE-1:0] IF_addr_i,
    input  logic               IF_read_i,
    output logic               IF_valid_o,
    output logic [31:0]        IF_data_o,
    input  logic [BITSIZE-1:0] D_addr_i,
    input  logic               D_read_i,
    input  logic               D_write_i,
    input  logic [31:0]        D_wdata_i,
    input  logic [3:0]         D_be_i,
    output logic               D_valid_o,
    output logic [31:0]        D_data_o,
    output logic [BITSIZE-1:0] MEM_addr_o,
    output logic               MEM_read_o,
    output logic               MEM_write_o,
    output logic [31:0]        MEM_wdata_o,
    output logic [3:0]         MEM_be_o,
    input  logic [31:0]        MEM_data_i,
    input  logic               MEM_valid_i
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, DRAIN = 2'd3;
    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic          d_req, starved, grant_i, grant_d;
    always_comb begin
        d_req   = D_read_i | D_write_i;
        starved = starve_cnt == SW'(STARVE_LIMIT);
        grant_i = state == IDLE && IF_read_i && !flush_i && (!d_req || starved);
        grant_d = state == IDLE && d_req && !grant_i;
    end
    assign IF_valid_o = state == SERVE_I && MEM_valid_i && !flush_i;
    assign D_valid_o  = state == SERVE_D && MEM_valid_i;
    assign IF_data_o  = MEM_data_i;
    assign D_data_o   = MEM_data_i;
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            MEM_addr_o  <= '0;
            MEM_read_o  <= 1'b0;
            MEM_write_o <= 1'b0;
            MEM_wdata_o <= '0;
            MEM_be_o    <= '0;
        end else begin
            if (grant_i)
                starve_cnt <= '0;
            else if (grant_d && IF_read_i && !starved)
                starve_cnt <= starve_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state       <= SERVE_I;
                        MEM_addr_o  <= IF_addr_i;
                        MEM_read_o  <= 1'b1;
                        MEM_write_o <= 1'b0;
                        MEM_wdata_o <= '0;
                        MEM_be_o    <= 4'hF;
                    end else if (grant_d) begin
                        state       <= SERVE_D;
                        MEM_addr_o  <= D_addr_i;
                        MEM_read_o  <= D_read_i;
                        MEM_write_o <= D_write_i;
                        MEM_wdata_o <= D_wdata_i;
                        MEM_be_o    <= D_write_i ? D_be_i : 4'hF;
                    end
                end
                SERVE_I: begin
                    if (MEM_valid_i) begin
                        state      <= IDLE;
                        MEM_read_o <= 1'b0;
                    end else if (flush_i)
                        state <= DRAIN;
                end
                SERVE_D: begin
                    if (MEM_valid_i) begin
                        state       <= IDLE;
                        MEM_read_o  <= 1'b0;
                        MEM_write_o <= 1'b0;
                    end
                end
                default: begin
                    if (MEM_valid_i) begin
                        state      <= IDLE;
                        MEM_read_o <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
